// File: rtl/det_cnt_pkg.sv
// rtl/det_cnt_pkg.sv - shared constants and state encoding for the detector event counter
package det_cnt_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int ST_W      = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_ALARM = 2'b10
    } state_t;
endpackage

// File: rtl/det_event_if.sv
// rtl/det_event_if.sv - detector input, control and status bundle for det_event_counter
interface det_event_if
    import det_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             det_in;
    logic             enable;
    logic             clear;
    logic             ack;
    logic [CNT_W-1:0] threshold;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] max_run;
    logic             rise_pulse;
    logic             irq_pulse;
    logic             alarm;
    logic             sat;

    modport master (
        output det_in, enable, clear, ack, threshold,
        input  count, max_run, rise_pulse, irq_pulse, alarm, sat
    );

    modport slave (
        input  det_in, enable, clear, ack, threshold,
        output count, max_run, rise_pulse, irq_pulse, alarm, sat
    );
endinterface

// File: rtl/det_rise_edge.sv
// rtl/det_rise_edge.sv - one-cycle-delay register and rising-edge strobe for a same-domain level
module det_rise_edge (
    input  logic clk,
    input  logic rst_b,
    input  logic din,
    output logic rise
);
    logic det_d_q;
    logic det_d_d;

    always_comb begin
        det_d_d = din;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            det_d_q <= 1'b0;
        end else begin
            det_d_q <= det_d_d;
        end
    end

    // det_d_q clears on reset, so a level already high at release counts as a rise
    assign rise = din & ~det_d_q;
endmodule

// File: rtl/det_event_counter.sv
// rtl/det_event_counter.sv - saturating event counter, run-length tracker and threshold alarm
module det_event_counter
    import det_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_b,
    det_event_if.slave  bus
);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cur_run_q, cur_run_d;
    logic [CNT_W-1:0] max_run_q, max_run_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             irq_pulse_q, irq_pulse_d;
    logic             alarm_q, alarm_d;
    logic             sat_q, sat_d;
    logic             rise;
    logic             event_inc;

    det_rise_edge u_rise (
        .clk   (clk),
        .rst_b (rst_b),
        .din   (bus.det_in),
        .rise  (rise)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cur_run_d    = cur_run_q;
        max_run_d    = max_run_q;
        sat_d        = sat_q;
        irq_pulse_d  = 1'b0;
        rise_pulse_d = rise;
        event_inc    = rise && bus.enable && (state_q == ST_ARMED || state_q == ST_ALARM);

        if (bus.enable) begin
            if (!bus.det_in) begin
                cur_run_d = '0;
            end else if (cur_run_q != ALL_ONES) begin
                cur_run_d = cur_run_q + 1'b1;
            end
            if (cur_run_d > max_run_q) begin
                max_run_d = cur_run_d;
            end
            if (max_run_d == ALL_ONES) begin
                sat_d = 1'b1;
            end
        end

        if (event_inc) begin
            if (count_q != ALL_ONES) begin
                count_d = count_q + 1'b1;
            end
            if (count_d == ALL_ONES) begin
                sat_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (event_inc && bus.threshold != '0 && count_d >= bus.threshold) begin
                    state_d     = ST_ALARM;
                    irq_pulse_d = 1'b1;
                end
            end
            ST_ALARM: begin
                state_d = ST_ALARM;
            end
            default: state_d = ST_IDLE;
        endcase

        // ack/clear drop any coincident event; exit target depends only on enable
        if (bus.clear || (bus.ack && state_q == ST_ALARM)) begin
            count_d     = '0;
            irq_pulse_d = 1'b0;
            state_d     = bus.enable ? ST_ARMED : ST_IDLE;
        end
        if (bus.clear) begin
            cur_run_d = '0;
            max_run_d = '0;
            sat_d     = 1'b0;
        end

        alarm_d = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            cur_run_q    <= '0;
            max_run_q    <= '0;
            rise_pulse_q <= 1'b0;
            irq_pulse_q  <= 1'b0;
            alarm_q      <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cur_run_q    <= cur_run_d;
            max_run_q    <= max_run_d;
            rise_pulse_q <= rise_pulse_d;
            irq_pulse_q  <= irq_pulse_d;
            alarm_q      <= alarm_d;
            sat_q        <= sat_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.max_run    = max_run_q;
    assign bus.rise_pulse = rise_pulse_q;
    assign bus.irq_pulse  = irq_pulse_q;
    assign bus.alarm      = alarm_q;
    assign bus.sat        = sat_q;
endmodule

// File: tb/tb_det_event_counter.sv
// tb/tb_det_event_counter.sv - directed self-checking bench for det_event_counter
module tb_det_event_counter;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_b;
    int   total;
    int   passed;
    int   failed;

    det_event_if #(.CNT_W(CNT_W)) bus ();

    det_event_counter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 0);
        chk({tag, "_max_run"}, 32'(bus.max_run), 0);
        chk({tag, "_rise"}, 32'(bus.rise_pulse), 0);
        chk({tag, "_irq"}, 32'(bus.irq_pulse), 0);
        chk({tag, "_alarm"}, 32'(bus.alarm), 0);
        chk({tag, "_sat"}, 32'(bus.sat), 0);
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        rst_b = 1'b0;
        bus.det_in = 1'b0; bus.enable = 1'b0; bus.clear = 1'b0; bus.ack = 1'b0;
        bus.threshold = '0;

        // reset, then idle pulses with enable low
        tick(); tick();
        chk_all_zero("reset");
        rst_b = 1'b1;
        bus.det_in = 1'b1; tick();
        chk("idle_rise1", 32'(bus.rise_pulse), 1);
        chk("idle_count1", 32'(bus.count), 0);
        bus.det_in = 1'b0; tick();
        chk("idle_fall", 32'(bus.rise_pulse), 0);
        chk("idle_max_run", 32'(bus.max_run), 0);
        bus.det_in = 1'b1; tick();
        chk("idle_rise2", 32'(bus.rise_pulse), 1);
        chk("idle_count2", 32'(bus.count), 0);
        bus.det_in = 1'b0; tick();

        // basic count to threshold 3
        bus.enable = 1'b1; bus.threshold = 4'd3; tick();
        chk("armed_no_alarm", 32'(bus.alarm), 0);
        for (int k = 1; k <= 3; k++) begin
            bus.det_in = 1'b1; tick();
            chk($sformatf("basic_count%0d", k), 32'(bus.count), k);
            chk($sformatf("basic_irq%0d", k), 32'(bus.irq_pulse), (k == 3) ? 1 : 0);
            chk($sformatf("basic_alarm%0d", k), 32'(bus.alarm), (k == 3) ? 1 : 0);
            tick();
            chk($sformatf("basic_irq_off%0d", k), 32'(bus.irq_pulse), 0);
            bus.det_in = 1'b0; tick();
        end
        chk("basic_alarm_held", 32'(bus.alarm), 1);
        chk("basic_max_run", 32'(bus.max_run), 2);

        // ack colliding with a rise: event dropped, pulse still seen
        bus.ack = 1'b1; bus.det_in = 1'b1; tick();
        bus.ack = 1'b0;
        chk("ack_count", 32'(bus.count), 0);
        chk("ack_rise", 32'(bus.rise_pulse), 1);
        chk("ack_alarm", 32'(bus.alarm), 0);
        chk("ack_irq", 32'(bus.irq_pulse), 0);
        bus.det_in = 1'b0; tick();
        bus.det_in = 1'b1; tick();
        chk("armed_after_ack", 32'(bus.count), 1);
        bus.det_in = 1'b0; tick();

        // threshold lowered to the current count: alarm waits for next event
        bus.threshold = 4'd1; tick();
        chk("thr_low_no_alarm", 32'(bus.alarm), 0);
        chk("thr_low_no_irq", 32'(bus.irq_pulse), 0);
        bus.det_in = 1'b1; tick();
        chk("thr_low_count", 32'(bus.count), 2);
        chk("thr_low_irq", 32'(bus.irq_pulse), 1);
        bus.det_in = 1'b0; tick();
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0;
        chk("clear_alarm", 32'(bus.alarm), 0);
        chk("clear_count", 32'(bus.count), 0);
        chk("clear_max_run", 32'(bus.max_run), 0);

        // run length: 5 high, 1 low, 3 high
        bus.threshold = '0;
        bus.det_in = 1'b1;
        repeat (5) tick();
        chk("run5_max", 32'(bus.max_run), 5);
        bus.det_in = 1'b0; tick();
        bus.det_in = 1'b1;
        repeat (3) tick();
        bus.det_in = 1'b0; tick();
        chk("run3_max", 32'(bus.max_run), 5);
        chk("run_count", 32'(bus.count), 2);

        // count saturation with threshold 0
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            bus.det_in = 1'b1; tick();
            bus.det_in = 1'b0; tick();
            if (k == 14) begin
                chk("sat_count14", 32'(bus.count), 14);
                chk("sat_flag14", 32'(bus.sat), 0);
            end
            if (k == 15) begin
                chk("sat_count15", 32'(bus.count), 15);
                chk("sat_flag15", 32'(bus.sat), 1);
            end
        end
        chk("sat_count17", 32'(bus.count), 15);
        chk("sat_no_alarm", 32'(bus.alarm), 0);
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0;
        chk("sat_clear_count", 32'(bus.count), 0);
        chk("sat_clear_flag", 32'(bus.sat), 0);

        // run-length saturation
        bus.det_in = 1'b1;
        repeat (16) tick();
        chk("run_sat_max", 32'(bus.max_run), 15);
        chk("run_sat_flag", 32'(bus.sat), 1);
        bus.det_in = 1'b0; tick();

        // sync reset while in ALARM with det_in high
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0;
        bus.threshold = 4'd1;
        bus.det_in = 1'b1; tick();
        chk("pre_rst_alarm", 32'(bus.alarm), 1);
        rst_b = 1'b0; tick();
        chk_all_zero("mid_rst");
        rst_b = 1'b1; tick();
        chk("post_rst_rise", 32'(bus.rise_pulse), 1);
        chk("post_rst_count", 32'(bus.count), 0);
        tick();
        chk("post_rst_rise_once", 32'(bus.rise_pulse), 0);
        tick();
        chk("post_rst_no_alarm", 32'(bus.alarm), 0);
        chk("post_rst_count_held", 32'(bus.count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
